// File: rtl/row_buf_ctrl_pkg.sv
// Shared types and constants for the 7x7 row-buffer sequencing controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package row_buf_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        STREAM = 2'd2,
        FLUSH  = 2'd3
    } state_t;

    // Bottom-border mux select encodings
    localparam logic [1:0] BTM_DIRECT   = 2'd0;
    localparam logic [1:0] BTM_3RD_LAST = 2'd1;
    localparam logic [1:0] BTM_2ND_LAST = 2'd2;
    localparam logic [1:0] BTM_LAST     = 2'd3;

    // Mask half-width of the 7x7 datapath; priming and flushing both span this many rows
    localparam int HALF_MASK  = 3;
    localparam int PRIME_ROWS = HALF_MASK;
    localparam int FLUSH_ROWS = HALF_MASK;

endpackage

// File: rtl/frame_pos_counter.sv
// Column/row position counter pair with enable, clear (to 0,0) and load (to col 1,row 0).
// Latency: registered, updates on the edge after en/clr/load.
// Backpressure: holds its value whenever en, clr and load are all low.
module frame_pos_counter #(
    parameter int COLS = 340,
    parameter int CW   = 9,
    parameter int RW   = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    input  logic          load,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic          col_wrap
);

    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

    // The next enabled step wraps the column and advances the row
    assign col_wrap = (col == COL_LAST);

    // Clear beats load beats count; load marks the sof pixel as already taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (clr) begin
            col <= '0;
            row <= '0;
        end else if (load) begin
            col <= CW'(1);
            row <= '0;
        end else if (en) begin
            if (col_wrap) begin
                col <= '0;
                row <= row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

endmodule

// File: rtl/row_buffer_ctrl.sv
// Frame sequencer for the 7x7 row buffer: prime/stream/flush, border selects, output coordinates.
// Latency: column (r,c) is valid in the same cycle as the handshake of pixel (r+3,c); selects are combinational.
// Backpressure: out_ready low stalls input in STREAM and stalls flush; optional sof resync via ROW_CTRL_SOF_RESYNC_EN.
module row_buffer_ctrl
    import row_buf_ctrl_pkg::*;
#(
    parameter int ROW_WIDTH = 340,
    parameter int NUM_ROWS  = 240,
    localparam int CW = $clog2(ROW_WIDTH),
    localparam int RW = $clog2(NUM_ROWS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pix_in_valid,
    input  logic          pix_in_sof,
    output logic          pix_in_ready,
    input  logic          out_ready,
    output logic          buf_shift_en,
    output logic          sel_top_row,
    output logic [1:0]    sel_btm_row,
    output logic          col_valid,
    output logic [RW-1:0] out_row,
    output logic [CW-1:0] out_col,
    output logic          out_sof,
    output logic          out_eol,
    output logic          frame_done,
    output logic          sync_err
);

    localparam logic [CW-1:0] COL_LAST   = CW'(ROW_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(NUM_ROWS - 1);
    localparam logic [RW-1:0] PRIME_LAST = RW'(PRIME_ROWS - 1);
    localparam logic [RW-1:0] FLUSH_LAST = RW'(FLUSH_ROWS - 1);
    localparam logic [RW-1:0] ROW_OFS    = RW'(HALF_MASK);
    localparam logic [RW-1:0] FLUSH_BASE = RW'(NUM_ROWS - FLUSH_ROWS);

    state_t        state, state_nxt;
    logic [CW-1:0] col_cnt;
    logic [RW-1:0] row_cnt;
    logic          col_wrap;
    logic          cnt_en, cnt_clr, cnt_load;
    logic          done_nxt, resync, resync_req;

`ifdef ROW_CTRL_SOF_RESYNC_EN
    assign resync_req = pix_in_sof;
`else
    assign resync_req = 1'b0;
`endif

    frame_pos_counter #(
        .COLS (ROW_WIDTH),
        .CW   (CW),
        .RW   (RW)
    ) u_pos (
        .clk      (clk),
        .rst      (reset),
        .en       (cnt_en),
        .clr      (cnt_clr),
        .load     (cnt_load),
        .col      (col_cnt),
        .row      (row_cnt),
        .col_wrap (col_wrap)
    );

    // State register plus the registered one-cycle pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            state      <= state_nxt;
            frame_done <= done_nxt;
            sync_err   <= resync;
        end
    end

    // Next state, counter controls and all per-cycle buffer/handshake outputs
    always_comb begin
        state_nxt    = state;
        pix_in_ready = 1'b0;
        buf_shift_en = 1'b0;
        sel_top_row  = 1'b0;
        sel_btm_row  = BTM_DIRECT;
        col_valid    = 1'b0;
        out_row      = '0;
        out_col      = '0;
        cnt_en       = 1'b0;
        cnt_clr      = 1'b0;
        cnt_load     = 1'b0;
        done_nxt     = 1'b0;
        resync       = 1'b0;
        case (state)
            IDLE: begin
                pix_in_ready = 1'b1;
                // Non-sof pixels are accepted and dropped so upstream cannot wedge
                if (pix_in_valid && pix_in_sof) begin
                    buf_shift_en = 1'b1;
                    sel_top_row  = 1'b1;
                    cnt_load     = 1'b1;
                    state_nxt    = PRIME;
                end
            end
            PRIME: begin
                pix_in_ready = 1'b1;
                sel_top_row  = 1'b1;
                if (pix_in_valid) begin
                    buf_shift_en = 1'b1;
                    if (resync_req) begin
                        cnt_load = 1'b1;
                        resync   = 1'b1;
                    end else begin
                        cnt_en = 1'b1;
                        if (col_wrap && row_cnt == PRIME_LAST) begin
                            state_nxt = STREAM;
                        end
                    end
                end
            end
            STREAM: begin
                pix_in_ready = out_ready;
                if (pix_in_valid && out_ready) begin
                    buf_shift_en = 1'b1;
                    if (resync_req) begin
                        // The restarting pixel is row 0 of a new frame, so it primes
                        sel_top_row = 1'b1;
                        cnt_load    = 1'b1;
                        resync      = 1'b1;
                        state_nxt   = PRIME;
                    end else begin
                        col_valid = 1'b1;
                        cnt_en    = 1'b1;
                        out_row   = row_cnt - ROW_OFS;
                        out_col   = col_cnt;
                        if (col_wrap && row_cnt == ROW_LAST) begin
                            cnt_clr   = 1'b1;
                            state_nxt = FLUSH;
                        end
                    end
                end
            end
            FLUSH: begin
                case (row_cnt[1:0])
                    2'd0:    sel_btm_row = BTM_3RD_LAST;
                    2'd1:    sel_btm_row = BTM_2ND_LAST;
                    default: sel_btm_row = BTM_LAST;
                endcase
                if (out_ready) begin
                    buf_shift_en = 1'b1;
                    col_valid    = 1'b1;
                    cnt_en       = 1'b1;
                    out_row      = FLUSH_BASE + row_cnt;
                    out_col      = col_cnt;
                    if (col_wrap && row_cnt == FLUSH_LAST) begin
                        cnt_clr   = 1'b1;
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign out_sof = col_valid && (out_row == '0) && (out_col == '0);
    assign out_eol = col_valid && (out_col == COL_LAST);

endmodule

// File: tb/tb_row_buffer_ctrl.sv
// Directed bench for row_buffer_ctrl with a 4x8 frame.
// Latency: checks same-cycle column timing and the frame_done pulse one cycle later.
// Backpressure: covers out_ready stalls, input gaps, IDLE drops, mid-frame reset and sof.
module tb_row_buffer_ctrl;

    localparam int RWID = 4;
    localparam int NROW = 8;
    localparam int NPIX = RWID * NROW;

    logic       clk;
    logic       reset;
    logic       pix_in_valid;
    logic       pix_in_sof;
    logic       pix_in_ready;
    logic       out_ready;
    logic       buf_shift_en;
    logic       sel_top_row;
    logic [1:0] sel_btm_row;
    logic       col_valid;
    logic [2:0] out_row;
    logic [1:0] out_col;
    logic       out_sof;
    logic       out_eol;
    logic       frame_done;
    logic       sync_err;

    row_buffer_ctrl #(.ROW_WIDTH(RWID), .NUM_ROWS(NROW)) dut (
        .clk          (clk),
        .reset        (reset),
        .pix_in_valid (pix_in_valid),
        .pix_in_sof   (pix_in_sof),
        .pix_in_ready (pix_in_ready),
        .out_ready    (out_ready),
        .buf_shift_en (buf_shift_en),
        .sel_top_row  (sel_top_row),
        .sel_btm_row  (sel_btm_row),
        .col_valid    (col_valid),
        .out_row      (out_row),
        .out_col      (out_col),
        .out_sof      (out_sof),
        .out_eol      (out_eol),
        .frame_done   (frame_done),
        .sync_err     (sync_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total, bad;
    int n_shift, n_top, top_bad, first_pix, n_cols, seq_err, btm_bad;
    int n_fd, fd_cyc, last_col_cyc, n_sof, n_eol, n_stall, stall_bad;
    int drop_shift, n_sync, sync_cyc, resync_cyc, timed_out;
    logic [1:0]  btm_q[$];
    logic [13:0] rst_outs;
    logic        rst_rdy;

    // Drives one frame (optional drops, stall, mid-frame sof, reset) and records what it sees
    task automatic run_frame(input bit gaps, input int pre_drop, input int bp_at,
                             input int sof_at, input int rst_at);
        int p, pre, cyc, bp_cnt, exp_r, exp_c;
        bit hs, resynced, fin;
        logic [2:0] er;
        logic [1:0] ec;
        p = 0; pre = 0; cyc = 0; bp_cnt = 0; exp_r = 0; exp_c = 0;
        resynced = 0; fin = 0;
        n_shift = 0; n_top = 0; top_bad = 0; first_pix = -1; n_cols = 0; seq_err = 0;
        btm_bad = 0; n_fd = 0; fd_cyc = -1; last_col_cyc = -1; n_sof = 0; n_eol = 0;
        n_stall = 0; stall_bad = 0; drop_shift = 0; n_sync = 0; sync_cyc = -1;
        resync_cyc = -1; timed_out = 0;
        btm_q.delete();
        while (!fin) begin
            @(negedge clk);
            pix_in_valid = 1'b0;
            pix_in_sof   = 1'b0;
            out_ready    = !(gaps && (cyc % 2 == 1));
            if (pre < pre_drop) begin
                pix_in_valid = 1'b1;
            end else if (p < NPIX) begin
                pix_in_valid = gaps ? (cyc % 2 == 0) : 1'b1;
                pix_in_sof   = (p == 0) || (p == sof_at && !resynced);
            end
            if (bp_at >= 0 && p == bp_at && bp_cnt < 5) begin
                out_ready = 1'b0;
                bp_cnt++;
            end
            if (rst_at >= 0 && p == rst_at) reset = 1'b1;
            #1;
            hs = pix_in_valid && pix_in_ready;
            if (reset) begin
                rst_outs = {buf_shift_en, sel_top_row, sel_btm_row, col_valid, out_row,
                            out_col, out_sof, out_eol, frame_done, sync_err};
                rst_rdy  = pix_in_ready;
                fin = 1;
            end else if (pre < pre_drop) begin
                if (buf_shift_en) drop_shift++;
                if (hs) pre++;
            end else begin
                if (buf_shift_en) n_shift++;
                if (sel_top_row) begin
                    n_top++;
                    if (p >= 3 * RWID) top_bad++;
                end
                if (col_valid) begin
                    er = exp_r[2:0];
                    ec = exp_c[1:0];
                    if (n_cols == 0) first_pix = p;
                    if (out_row !== er || out_col !== ec ||
                        out_sof !== (exp_r == 0 && exp_c == 0) || out_eol !== (exp_c == RWID - 1))
                        seq_err++;
                    if (p >= NPIX) btm_q.push_back(sel_btm_row);
                    else if (sel_btm_row !== 2'd0) btm_bad++;
                    n_cols++;
                    last_col_cyc = cyc;
                    exp_c++;
                    if (exp_c == RWID) begin
                        exp_c = 0;
                        exp_r++;
                    end
                end
                if (out_sof) n_sof++;
                if (out_eol) n_eol++;
                if (sync_err) begin
                    n_sync++;
                    sync_cyc = cyc;
                end
                if (!gaps && !out_ready) begin
                    n_stall++;
                    if (pix_in_ready || buf_shift_en || col_valid) stall_bad++;
                end
                if (frame_done) begin
                    n_fd++;
                    fd_cyc = cyc;
                    fin = 1;
                end
                if (hs) begin
                    if (pix_in_sof && p == sof_at && !resynced) begin
                        resynced   = 1;
                        resync_cyc = cyc;
`ifdef ROW_CTRL_SOF_RESYNC_EN
                        p = 1; exp_r = 0; exp_c = 0;
`else
                        p++;
`endif
                    end else begin
                        p++;
                    end
                end
            end
            cyc++;
            if (cyc > 300) begin
                timed_out = 1;
                fin = 1;
            end
        end
        pix_in_valid = 1'b0;
        pix_in_sof   = 1'b0;
        out_ready    = 1'b1;
        if (reset) begin
            @(negedge clk);
            reset = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        pix_in_valid = 1'b0; pix_in_sof = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if ({buf_shift_en, sel_top_row, sel_btm_row, col_valid, out_row, out_col,
             out_sof, out_eol, frame_done, sync_err} !== 14'd0) begin
            bad++; $display("FAIL reset_outs got %b want 0", {buf_shift_en, sel_top_row, sel_btm_row,
                col_valid, out_row, out_col, out_sof, out_eol, frame_done, sync_err});
        end
        total++;
        if (pix_in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got %b want 1", pix_in_ready); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_continuous();
        int bb;
        run_frame(0, 0, -1, -1, -1);
        total++; if (timed_out != 0) begin bad++; $display("FAIL cont_timeout got %0d want 0", timed_out); end
        total++; if (n_shift != 44) begin bad++; $display("FAIL cont_shift got %0d want 44", n_shift); end
        total++; if (n_top != 12) begin bad++; $display("FAIL cont_top got %0d want 12", n_top); end
        total++; if (top_bad != 0) begin bad++; $display("FAIL cont_top_late got %0d want 0", top_bad); end
        total++; if (first_pix != 12) begin bad++; $display("FAIL cont_first_col got %0d want 12", first_pix); end
        total++; if (n_cols != 32) begin bad++; $display("FAIL cont_cols got %0d want 32", n_cols); end
        total++; if (seq_err != 0) begin bad++; $display("FAIL cont_seq got %0d want 0", seq_err); end
        total++; if (n_sof != 1) begin bad++; $display("FAIL cont_sof got %0d want 1", n_sof); end
        total++; if (n_eol != 8) begin bad++; $display("FAIL cont_eol got %0d want 8", n_eol); end
        total++; if (btm_bad != 0) begin bad++; $display("FAIL cont_btm_stream got %0d want 0", btm_bad); end
        total++; if (btm_q.size() != 12) begin bad++; $display("FAIL cont_btm_len got %0d want 12", btm_q.size()); end
        bb = 0;
        for (int i = 0; i < btm_q.size(); i++) if (btm_q[i] !== 2'(1 + i / 4)) bb++;
        total++; if (bb != 0) begin bad++; $display("FAIL cont_btm_seq got %0d wrong want 0", bb); end
        total++; if (last_col_cyc != 43) begin bad++; $display("FAIL cont_last_col got %0d want 43", last_col_cyc); end
        total++; if (n_fd != 1) begin bad++; $display("FAIL cont_done_cnt got %0d want 1", n_fd); end
        total++; if (fd_cyc != 44) begin bad++; $display("FAIL cont_done_cyc got %0d want 44", fd_cyc); end
        total++; if (n_sync != 0) begin bad++; $display("FAIL cont_sync got %0d want 0", n_sync); end
    endtask

    task automatic test_backpressure();
        run_frame(0, 0, 20, -1, -1);
        total++; if (n_stall != 5) begin bad++; $display("FAIL bp_stall_cycles got %0d want 5", n_stall); end
        total++; if (stall_bad != 0) begin bad++; $display("FAIL bp_stall_activity got %0d want 0", stall_bad); end
        total++; if (n_cols != 32) begin bad++; $display("FAIL bp_cols got %0d want 32", n_cols); end
        total++; if (seq_err != 0) begin bad++; $display("FAIL bp_seq got %0d want 0", seq_err); end
        total++; if (last_col_cyc != 48) begin bad++; $display("FAIL bp_last_col got %0d want 48", last_col_cyc); end
    endtask

    task automatic test_idle_drop();
        run_frame(0, 3, -1, -1, -1);
        total++; if (drop_shift != 0) begin bad++; $display("FAIL drop_shift got %0d want 0", drop_shift); end
        total++; if (n_shift != 44) begin bad++; $display("FAIL drop_frame_shift got %0d want 44", n_shift); end
        total++; if (first_pix != 12) begin bad++; $display("FAIL drop_first_col got %0d want 12", first_pix); end
        total++; if (seq_err != 0 || n_cols != 32) begin bad++; $display("FAIL drop_cols got %0d/%0d want 32/0", n_cols, seq_err); end
        total++; if (last_col_cyc != 46) begin bad++; $display("FAIL drop_last_col got %0d want 46", last_col_cyc); end
    endtask

    task automatic test_reset_mid_stream();
        run_frame(0, 0, -1, -1, 18);
        total++; if (rst_outs !== 14'd0) begin bad++; $display("FAIL midrst_outs got %b want 0", rst_outs); end
        total++; if (rst_rdy !== 1'b1) begin bad++; $display("FAIL midrst_ready got %b want 1", rst_rdy); end
        run_frame(0, 0, -1, -1, -1);
        total++; if (n_shift != 44) begin bad++; $display("FAIL midrst_shift got %0d want 44", n_shift); end
        total++; if (n_cols != 32 || seq_err != 0) begin bad++; $display("FAIL midrst_cols got %0d/%0d want 32/0", n_cols, seq_err); end
        total++; if (fd_cyc != 44) begin bad++; $display("FAIL midrst_done_cyc got %0d want 44", fd_cyc); end
    endtask

    task automatic test_sof_mid_frame();
        run_frame(0, 0, -1, 14, -1);
        total++; if (seq_err != 0) begin bad++; $display("FAIL sof_seq got %0d want 0", seq_err); end
`ifdef ROW_CTRL_SOF_RESYNC_EN
        total++; if (n_sync != 1) begin bad++; $display("FAIL sof_sync_cnt got %0d want 1", n_sync); end
        total++; if (sync_cyc != 15) begin bad++; $display("FAIL sof_sync_cyc got %0d want 15", sync_cyc); end
        total++; if (n_cols != 34) begin bad++; $display("FAIL sof_cols got %0d want 34", n_cols); end
        total++; if (n_sof != 2) begin bad++; $display("FAIL sof_outsof got %0d want 2", n_sof); end
`else
        total++; if (n_sync != 0) begin bad++; $display("FAIL sof_sync_cnt got %0d want 0", n_sync); end
        total++; if (n_cols != 32) begin bad++; $display("FAIL sof_cols got %0d want 32", n_cols); end
        total++; if (fd_cyc != 44) begin bad++; $display("FAIL sof_done_cyc got %0d want 44", fd_cyc); end
`endif
    endtask

    task automatic test_input_gaps();
        run_frame(1, 0, -1, -1, -1);
        total++; if (n_cols != 32 || seq_err != 0) begin bad++; $display("FAIL gap_cols got %0d/%0d want 32/0", n_cols, seq_err); end
        total++; if (n_shift != 44) begin bad++; $display("FAIL gap_shift got %0d want 44", n_shift); end
        total++; if (last_col_cyc != 86) begin bad++; $display("FAIL gap_last_col got %0d want 86", last_col_cyc); end
        total++; if (fd_cyc != 87) begin bad++; $display("FAIL gap_done_cyc got %0d want 87", fd_cyc); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        pix_in_valid = 1'b0;
        pix_in_sof   = 1'b0;
        out_ready    = 1'b1;
        test_reset();
        test_continuous();
        test_backpressure();
        test_idle_drop();
        test_reset_mid_stream();
        test_sof_mid_frame();
        test_input_gaps();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
